ex_alu_stage: RTL
=================

// Module: ex_alu_stage
// PURPOSE
//  Execute stage of the 6-stage RV32I pipeline; sits directly downstream of the ALU decoder.
//  Consumes the 5-bit ALU control code and operands, computes the result and resolves branches.
//  Holds the result in a single-entry EX output register behind a valid/ready handshake.
//  Issues a one-cycle redirect to fetch for taken branches; flushable by the hazard unit.
// PARAMETERS
//  XLEN  32  datapath width; shift amount = src_b[$clog2(XLEN)-1:0]
// PORTS
//  clk            in   1     clock; all state changes on posedge
//  rst_n          in   1     synchronous active-low reset
//  in_valid       in   1     decode stage presents an instruction
//  in_ready       out  1     stage can accept this cycle
//  alu_control    in   5     0 add,1 sub,2 and,3 or,4 xor,5 slt,6 sll,7 srl,8 sra,9 sltu
//  is_branch      in   1     instruction is a conditional branch
//  funct3         in   3     branch condition select
//  src_a, src_b   in   XLEN  ALU operands (forwarded values)
//  pc, imm        in   XLEN  instruction PC and sign-extended immediate
//  rd_in          in   5     destination register
//  reg_write_in   in   1     writeback enable
//  flush          in   1     kill held and incoming instruction
//  out_valid      out  1     output register holds a live instruction
//  out_ready      in   1     downstream (MEM) accepts
//  out_result     out  XLEN  registered ALU result
//  out_rd         out  5     registered rd
//  out_reg_write  out  1     registered writeback enable
//  redirect_valid out  1     one-cycle pulse: taken branch
//  redirect_pc    out  XLEN  pc + imm of the taken branch
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): out_valid=0, redirect_valid=0; out_result, out_rd,
//   out_reg_write, redirect_pc=0. Reset overrides flush and any in-flight accept.
//  in_ready = !out_valid | out_ready (combinational); it does not depend on in_valid.
//  Accept = in_valid & in_ready & !flush. On accept: out_* load next cycle, out_valid=1.
//  Latency 1 cycle from accept to out_valid. The output register holds its contents
//   while out_valid & !out_ready.
//  out_valid clears when out_ready=1 and no new accept occurs in the same cycle.
//   Simultaneous drain and accept: the new entry replaces the old one, out_valid stays 1.
//  flush=1: out_valid->0 next cycle; the incoming instruction is dropped;
//   redirect_valid->0 next cycle.
//  ALU arithmetic is modulo 2^XLEN; sub = a + ~b + 1.
//   slt is signed, sltu is unsigned; both produce 0/1 zero-extended.
//   sra is an arithmetic shift.
//   Codes 10..31 produce result 0 (no X propagation).
//  Branch condition:
//   funct3 000 eq, 001 ne, 100 lt (signed), 101 ge (signed), 110 ltu, 111 geu.
//   funct3 010/011 = not taken.
//  Taken = accept & is_branch & cond. The cycle after a taken branch:
//   redirect_valid=1, redirect_pc=pc+imm (mod 2^XLEN). Otherwise redirect_valid=0.
//   The redirect fires exactly once and is independent of out_ready backpressure.
//  Branches drive out_reg_write from reg_write_in unchanged; decode drives 0 for branches.
// TESTING
//  1 Reset: hold rst_n=0 for 3 cycles with in_valid=1
//    -> out_valid=0, redirect_valid=0, in_ready=1.
//  2 ALU sweep: a=0xFFFF_FFF0, b=0x0000_0004.
//    add->0xFFFF_FFF4, sub->0xFFFF_FFEC, slt->1, sltu->0, sra->0xFFFF_FFFF,
//    srl->0x0FFF_FFFF, sll->0xFFFF_FF00. Code 12 -> 0.
//  3 Backpressure: accept add (result 5) while out_ready=0 for 3 cycles
//    -> result 5 held, in_ready=0; then out_ready=1 and a new input
//    -> back-to-back transfer, no bubble.
//  4 Branch: blt a=-1, b=1, pc=0x100, imm=0x20 -> next cycle redirect_valid=1,
//    redirect_pc=0x120 for exactly 1 cycle. bge with same operands -> no redirect.
//  5 Flush: flush=1 in the same cycle as a taken beq accept
//    -> no redirect, out_valid=0; the held entry is also dropped.
//  6 Wrap: beq a=b, pc=0xFFFF_FFF0, imm=0x20 -> redirect_pc=0x0000_0010.

Source files
------------

// File: rtl/ex_alu_stage_if.sv
// Decode-to-EX-to-MEM bundle: instruction in, registered result out, fetch redirect.
// master = the surrounding pipeline, slave = the EX stage itself.
interface ex_alu_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      alu_control;
    logic            is_branch;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_in;
    logic            reg_write_in;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_reg_write;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output in_valid, alu_control, is_branch, funct3, src_a, src_b, pc, imm,
               rd_in, reg_write_in, flush, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_reg_write,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  in_valid, alu_control, is_branch, funct3, src_a, src_b, pc, imm,
               rd_in, reg_write_in, flush, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_reg_write,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ex_alu_stage.sv
// RV32I execute stage: ALU + branch resolve, 1 cycle from accept into a single-entry output register.
// Backpressure: in_ready = !out_valid | out_ready; the taken-branch redirect pulse ignores out_ready.
module ex_alu_stage #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst_n,
    ex_alu_stage_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic            out_reg_write_q, out_reg_write_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic            accept;
    logic            lt_s;
    logic            lt_u;
    logic            cond;
    logic            taken;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    assign shamt = bus.src_b[SHW-1:0];
    assign lt_s  = $signed(bus.src_a) < $signed(bus.src_b);
    assign lt_u  = bus.src_a < bus.src_b;

    always_comb begin
        alu_res = '0;
        case (bus.alu_control)
            5'd0: alu_res = bus.src_a + bus.src_b;
            5'd1: alu_res = bus.src_a - bus.src_b;
            5'd2: alu_res = bus.src_a & bus.src_b;
            5'd3: alu_res = bus.src_a | bus.src_b;
            5'd4: alu_res = bus.src_a ^ bus.src_b;
            5'd5: alu_res = {{(XLEN-1){1'b0}}, lt_s};
            5'd6: alu_res = bus.src_a << shamt;
            5'd7: alu_res = bus.src_a >> shamt;
            5'd8: alu_res = $unsigned($signed(bus.src_a) >>> shamt);
            5'd9: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            default: alu_res = '0;
        endcase
    end

    // funct3 010/011 are not legal branch encodings and fall through to not-taken.
    always_comb begin
        cond = 1'b0;
        case (bus.funct3)
            3'b000: cond = bus.src_a == bus.src_b;
            3'b001: cond = bus.src_a != bus.src_b;
            3'b100: cond = lt_s;
            3'b101: cond = !lt_s;
            3'b110: cond = lt_u;
            3'b111: cond = !lt_u;
            default: cond = 1'b0;
        endcase
    end

    assign taken = accept && bus.is_branch && cond;

    always_comb begin
        out_valid_d      = out_valid_q;
        out_result_d     = out_result_q;
        out_rd_d         = out_rd_q;
        out_reg_write_d  = out_reg_write_q;
        redirect_valid_d = taken;
        redirect_pc_d    = taken ? (bus.pc + bus.imm) : redirect_pc_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d     = 1'b1;
            out_result_d    = alu_res;
            out_rd_d        = bus.rd_in;
            out_reg_write_d = bus.reg_write_in;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            out_result_q     <= '0;
            out_rd_q         <= '0;
            out_reg_write_q  <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            out_valid_q      <= out_valid_d;
            out_result_q     <= out_result_d;
            out_rd_q         <= out_rd_d;
            out_reg_write_q  <= out_reg_write_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_result     = out_result_q;
    assign bus.out_rd         = out_rd_q;
    assign bus.out_reg_write  = out_reg_write_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
endmodule
